dtcm_port_arbiter: RTL and testbench

//  Shares the single DTCM data port between the core data-memory controller (CORE) and a
//  DMA/debug master (DMA). Sits between the data-memory controller / DMA and the DTCM block.

---
 rtl/dtcm_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_dtcm_port_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dtcm_port_arbiter.sv
// Purpose : shares the single DTCM data port between CORE and DMA; fixed CORE priority,
//           one outstanding read tracked and its data returned to the master that issued it.
// Latency : zero added request latency (combinational grant); read data forwarded same cycle.
// Backpressure: granted master's ready follows dtcm_ready; loser and all masters while a
//           read is outstanding see ready=0.
//
// Ports:
//   cpu_clk, cpu_rst            clock, synchronous active-high reset
//   core_* / dma_*              request (access, rd0_wr1, byte_strobe, write_data, addr),
//                               ready, read_data, read_data_valid per master
//   dtcm_*                      request out to DTCM, dtcm_ready / read return in
// Optional feature: define DTCM_ARB_ANTI_STARVE_EN to promote DMA over CORE after
// STARVE_LIMIT consecutive denied DMA cycles.

module dtcm_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                cpu_clk,
    input  logic                cpu_rst,

    input  logic                core_access,
    input  logic                core_rd0_wr1,
    input  logic [DATA_W/8-1:0] core_byte_strobe,
    input  logic [DATA_W-1:0]   core_write_data,
    input  logic [ADDR_W-1:0]   core_addr,
    output logic                core_ready,
    output logic [DATA_W-1:0]   core_read_data,
    output logic                core_read_data_valid,

    input  logic                dma_access,
    input  logic                dma_rd0_wr1,
    input  logic [DATA_W/8-1:0] dma_byte_strobe,
    input  logic [DATA_W-1:0]   dma_write_data,
    input  logic [ADDR_W-1:0]   dma_addr,
    output logic                dma_ready,
    output logic [DATA_W-1:0]   dma_read_data,
    output logic                dma_read_data_valid,

    output logic                dtcm_access,
    input  logic                dtcm_ready,
    output logic                dtcm_rd0_wr1,
    output logic [DATA_W/8-1:0] dtcm_byte_strobe,
    output logic [DATA_W-1:0]   dtcm_write_data,
    output logic [ADDR_W-1:0]   dtcm_addr,
    input  logic [DATA_W-1:0]   dtcm_read_data,
    input  logic                dtcm_read_data_valid
);

    typedef enum logic {ST_IDLE, ST_RD_WAIT} state_t;
    typedef enum logic {OWN_CORE, OWN_DMA}   owner_t;

    state_t state_q, state_d;
    owner_t rd_owner_q, rd_owner_d;

    logic can_grant;
    logic dma_promote;
    logic gnt_core;
    logic gnt_dma;
    logic rd_ret;

`ifdef DTCM_ARB_ANTI_STARVE_EN
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    logic [SC_W-1:0] starve_cnt_q, starve_cnt_d;

    assign dma_promote = (starve_cnt_q == STARVE_MAX);

    // Counts denied DMA cycles; any accepted DMA transfer restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (dma_access && dma_ready) begin
            starve_cnt_d = '0;
        end else if (dma_access && (starve_cnt_q != STARVE_MAX)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign dma_promote = 1'b0;
`endif

    // A new grant is possible when idle, or in the very cycle the outstanding
    // read returns (back-to-back reads). Nothing is granted while reset is high.
    assign can_grant = !cpu_rst && ((state_q == ST_IDLE) || dtcm_read_data_valid);
    assign gnt_dma   = can_grant && dma_access && (!core_access || dma_promote);
    assign gnt_core  = can_grant && core_access && !gnt_dma;

    // Read data is only forwarded when a read is actually outstanding; a valid
    // seen in IDLE (spurious or left over from before reset) is dropped.
    assign rd_ret = !cpu_rst && (state_q == ST_RD_WAIT) && dtcm_read_data_valid;

    always_comb begin
        dtcm_access      = 1'b0;
        dtcm_rd0_wr1     = 1'b0;
        dtcm_byte_strobe = '0;
        dtcm_write_data  = '0;
        dtcm_addr        = '0;
        core_ready       = 1'b0;
        dma_ready        = 1'b0;
        if (gnt_core) begin
            dtcm_access      = 1'b1;
            dtcm_rd0_wr1     = core_rd0_wr1;
            dtcm_byte_strobe = core_byte_strobe;
            dtcm_write_data  = core_write_data;
            dtcm_addr        = core_addr;
            core_ready       = dtcm_ready;
        end else if (gnt_dma) begin
            dtcm_access      = 1'b1;
            dtcm_rd0_wr1     = dma_rd0_wr1;
            dtcm_byte_strobe = dma_byte_strobe;
            dtcm_write_data  = dma_write_data;
            dtcm_addr        = dma_addr;
            dma_ready        = dtcm_ready;
        end
    end

    always_comb begin
        core_read_data_valid = 1'b0;
        core_read_data       = '0;
        dma_read_data_valid  = 1'b0;
        dma_read_data        = '0;
        if (rd_ret) begin
            if (rd_owner_q == OWN_DMA) begin
                dma_read_data_valid = 1'b1;
                dma_read_data       = dtcm_read_data;
            end else begin
                core_read_data_valid = 1'b1;
                core_read_data       = dtcm_read_data;
            end
        end
    end

    // A read accepted in the return cycle overrides the return-to-idle.
    always_comb begin
        state_d    = state_q;
        rd_owner_d = rd_owner_q;
        if (rd_ret) begin
            state_d = ST_IDLE;
        end
        if (dtcm_access && dtcm_ready && !dtcm_rd0_wr1) begin
            state_d    = ST_RD_WAIT;
            rd_owner_d = gnt_dma ? OWN_DMA : OWN_CORE;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q    <= ST_IDLE;
            rd_owner_q <= OWN_CORE;
        end else begin
            state_q    <= state_d;
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_dtcm_port_arbiter.sv
// Purpose : directed checks of the DTCM port arbiter (grant priority, read return,
//           stalls, reset abandonment, DMA starvation behaviour).
// Latency : inputs driven at the falling edge, outputs sampled 2 time units later.
// Backpressure: dtcm_ready driven directly by the bench.

module tb_dtcm_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              cpu_clk = 1'b0;
    logic              cpu_rst;
    logic              core_access, core_rd0_wr1;
    logic [3:0]        core_byte_strobe;
    logic [DATA_W-1:0] core_write_data;
    logic [ADDR_W-1:0] core_addr;
    logic              core_ready;
    logic [DATA_W-1:0] core_read_data;
    logic              core_read_data_valid;
    logic              dma_access, dma_rd0_wr1;
    logic [3:0]        dma_byte_strobe;
    logic [DATA_W-1:0] dma_write_data;
    logic [ADDR_W-1:0] dma_addr;
    logic              dma_ready;
    logic [DATA_W-1:0] dma_read_data;
    logic              dma_read_data_valid;
    logic              dtcm_access, dtcm_ready, dtcm_rd0_wr1;
    logic [3:0]        dtcm_byte_strobe;
    logic [DATA_W-1:0] dtcm_write_data;
    logic [ADDR_W-1:0] dtcm_addr;
    logic [DATA_W-1:0] dtcm_read_data;
    logic              dtcm_read_data_valid;

    int n_cmp = 0;
    int n_err = 0;
    logic exp_dma_gnt;

    always #5 cpu_clk = ~cpu_clk;

    dtcm_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(8)) dut (
        .cpu_clk              (cpu_clk),
        .cpu_rst              (cpu_rst),
        .core_access          (core_access),
        .core_rd0_wr1         (core_rd0_wr1),
        .core_byte_strobe     (core_byte_strobe),
        .core_write_data      (core_write_data),
        .core_addr            (core_addr),
        .core_ready           (core_ready),
        .core_read_data       (core_read_data),
        .core_read_data_valid (core_read_data_valid),
        .dma_access           (dma_access),
        .dma_rd0_wr1          (dma_rd0_wr1),
        .dma_byte_strobe      (dma_byte_strobe),
        .dma_write_data       (dma_write_data),
        .dma_addr             (dma_addr),
        .dma_ready            (dma_ready),
        .dma_read_data        (dma_read_data),
        .dma_read_data_valid  (dma_read_data_valid),
        .dtcm_access          (dtcm_access),
        .dtcm_ready           (dtcm_ready),
        .dtcm_rd0_wr1         (dtcm_rd0_wr1),
        .dtcm_byte_strobe     (dtcm_byte_strobe),
        .dtcm_write_data      (dtcm_write_data),
        .dtcm_addr            (dtcm_addr),
        .dtcm_read_data       (dtcm_read_data),
        .dtcm_read_data_valid (dtcm_read_data_valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Start a new cycle: wait for the falling edge and return all inputs to idle.
    task automatic cyc();
        @(negedge cpu_clk);
        cpu_rst              = 1'b0;
        core_access          = 1'b0;
        core_rd0_wr1         = 1'b0;
        core_byte_strobe     = 4'h0;
        core_write_data      = '0;
        core_addr            = '0;
        dma_access           = 1'b0;
        dma_rd0_wr1          = 1'b0;
        dma_byte_strobe      = 4'h0;
        dma_write_data       = '0;
        dma_addr             = '0;
        dtcm_ready           = 1'b1;
        dtcm_read_data       = '0;
        dtcm_read_data_valid = 1'b0;
    endtask

    task automatic core_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        core_access = 1'b1; core_rd0_wr1 = wr; core_addr = addr;
        core_write_data = data; core_byte_strobe = 4'hF;
    endtask

    task automatic dma_req(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        dma_access = 1'b1; dma_rd0_wr1 = wr; dma_addr = addr;
        dma_write_data = data; dma_byte_strobe = 4'h3;
    endtask

    initial begin
        // Reset with a pending request and a stray read valid: every output must be 0.
        cyc(); cpu_rst = 1'b1; core_req(1'b1, 32'h10, 32'h1);
        dtcm_read_data_valid = 1'b1; dtcm_read_data = 32'hFFFF_FFFF;
        #2;
        chk("rst_dtcm_access", dtcm_access, 0);
        chk("rst_core_ready", core_ready, 0);
        chk("rst_core_rvld", core_read_data_valid, 0);
        chk("rst_dma_rvld", dma_read_data_valid, 0);
        cyc(); cpu_rst = 1'b1;

        // CORE write reaches DTCM in the same cycle.
        cyc(); core_req(1'b1, 32'h10, 32'hA5A5_0001); #2;
        chk("wr_dtcm_access", dtcm_access, 1);
        chk("wr_dtcm_addr", dtcm_addr, 32'h10);
        chk("wr_dtcm_wdata", dtcm_write_data, 32'hA5A5_0001);
        chk("wr_dtcm_cmd", dtcm_rd0_wr1, 1);
        chk("wr_core_ready", core_ready, 1);

        // Simultaneous writes: CORE first, DMA next cycle.
        cyc(); core_req(1'b1, 32'h30, 32'h3); dma_req(1'b1, 32'h40, 32'h4); #2;
        chk("both_core_ready", core_ready, 1);
        chk("both_dma_ready", dma_ready, 0);
        chk("both_addr", dtcm_addr, 32'h30);
        cyc(); dma_req(1'b1, 32'h40, 32'h4); #2;
        chk("dma2_ready", dma_ready, 1);
        chk("dma2_addr", dtcm_addr, 32'h40);
        chk("dma2_strobe", dtcm_byte_strobe, 4'h3);

        // DMA read; data returns two cycles later while CORE waits.
        cyc(); dma_req(1'b0, 32'h20, 32'h0); #2;
        chk("dmard_ready", dma_ready, 1);
        chk("dmard_cmd", dtcm_rd0_wr1, 0);
        cyc(); core_req(1'b1, 32'h50, 32'h5); #2;
        chk("wait_core_ready", core_ready, 0);
        chk("wait_dtcm_access", dtcm_access, 0);
        chk("wait_dma_rvld", dma_read_data_valid, 0);
        cyc(); core_req(1'b1, 32'h50, 32'h5);
        dtcm_read_data_valid = 1'b1; dtcm_read_data = 32'hDEAD_BEEF; #2;
        chk("ret_dma_rvld", dma_read_data_valid, 1);
        chk("ret_dma_rdata", dma_read_data, 32'hDEAD_BEEF);
        chk("ret_core_rvld", core_read_data_valid, 0);
        chk("ret_core_rdata", core_read_data, 0);
        chk("ret_core_ready", core_ready, 1);
        chk("ret_addr", dtcm_addr, 32'h50);

        // Spurious valid in IDLE is dropped.
        cyc(); dtcm_read_data_valid = 1'b1; dtcm_read_data = 32'h1234_5678; #2;
        chk("spur_core_rvld", core_read_data_valid, 0);
        chk("spur_dma_rvld", dma_read_data_valid, 0);

        // Back-to-back reads: CORE read returns while DMA read is granted.
        cyc(); core_req(1'b0, 32'h60, 32'h0); #2;
        chk("b2b_core_ready", core_ready, 1);
        cyc(); dma_req(1'b0, 32'h70, 32'h0);
        dtcm_read_data_valid = 1'b1; dtcm_read_data = 32'h1111_1111; #2;
        chk("b2b_core_rvld", core_read_data_valid, 1);
        chk("b2b_core_rdata", core_read_data, 32'h1111_1111);
        chk("b2b_dma_rvld0", dma_read_data_valid, 0);
        chk("b2b_dma_ready", dma_ready, 1);
        cyc(); dtcm_read_data_valid = 1'b1; dtcm_read_data = 32'h2222_2222; #2;
        chk("b2b_dma_rvld", dma_read_data_valid, 1);
        chk("b2b_dma_rdata", dma_read_data, 32'h2222_2222);
        chk("b2b_core_rvld0", core_read_data_valid, 0);
        cyc(); dtcm_read_data_valid = 1'b1; #2;
        chk("b2b_idle_dma_rvld", dma_read_data_valid, 0);

        // DTCM stall: CORE read not accepted, no read becomes outstanding.
        cyc(); core_req(1'b0, 32'h80, 32'h0); dtcm_ready = 1'b0; #2;
        chk("stall_core_ready", core_ready, 0);
        chk("stall_dtcm_access", dtcm_access, 1);
        cyc(); core_req(1'b0, 32'h80, 32'h0); dtcm_ready = 1'b0; #2;
        chk("stall2_dtcm_access", dtcm_access, 1);
        cyc(); dtcm_read_data_valid = 1'b1; dtcm_read_data = 32'h3333_3333; #2;
        chk("stall_core_rvld", core_read_data_valid, 0);
        chk("stall_dma_rvld", dma_read_data_valid, 0);

        // Reset during RD_WAIT abandons the read.
        cyc(); core_req(1'b0, 32'h90, 32'h0); #2;
        chk("rstrd_core_ready", core_ready, 1);
        cyc(); cpu_rst = 1'b1; dtcm_read_data_valid = 1'b1; #2;
        chk("rstrd_core_rvld_in_rst", core_read_data_valid, 0);
        cyc(); core_req(1'b1, 32'hA0, 32'hA);
        dtcm_read_data_valid = 1'b1; dtcm_read_data = 32'h4444_4444; #2;
        chk("rstrd_core_rvld", core_read_data_valid, 0);
        chk("rstrd_dma_rvld", dma_read_data_valid, 0);
        chk("rstrd_idle_core_ready", core_ready, 1);

        // CORE writes every cycle with DMA requesting.
        for (int i = 0; i < 12; i++) begin
            cyc(); core_req(1'b1, 32'hB0 + i, 32'h0); dma_req(1'b1, 32'hC0, 32'h0); #2;
`ifdef DTCM_ARB_ANTI_STARVE_EN
            exp_dma_gnt = (i == 8);
`else
            exp_dma_gnt = 1'b0;
`endif
            chk($sformatf("starve_dma_ready_%0d", i), dma_ready, exp_dma_gnt);
            chk($sformatf("starve_core_ready_%0d", i), core_ready, !exp_dma_gnt);
        end

        cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
